out_display: RTL and testbench

Output stage of the SAP-1 datapath: consumes the 8-bit value the controller places on the shared bus at an OUT instruction, holds it in an output register, and presents it on a 4-digit multiplexed common-anode 7-segment display. A sequential double-dabble converter turns the held value into decimal digits. A refresh divider scans the digits. The block sits downstream of the bus and the A register, and is driven by the same gated clock as the other datapath registers.

---
 rtl/out_display.sv | 150 +++++++++++++++
 tb/tb_out_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/out_display.sv
// SAP-1 output stage: holds the OUT value, converts it to BCD (double dabble) and
// scans it onto a 4-digit common-anode 7-segment display. Optional: SIGNED_DISPLAY_EN.
module out_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] bus,
  output logic [7:0] out,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_CONV = 1'b1;

  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic             state;
  logic [19:0]      shift;
  logic [19:0]      shift_nxt;
  logic [2:0]       iter;
  logic [11:0]      bcd;
  logic [11:0]      bcd_nxt;
  logic             neg_pend;
  logic             neg_disp;
  logic             neg_nxt;
  logic             conv_done;
  logic [7:0]       conv_in;
  logic             load_neg;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [1:0]       scan_idx;
  logic [1:0]       idx_nxt;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

`ifdef SIGNED_DISPLAY_EN
  assign load_neg = bus[7];
  assign conv_in  = bus[7] ? (~bus + 8'd1) : bus;
`else
  assign load_neg = 1'b0;
  assign conv_in  = bus;
`endif

  assign busy = (state == S_CONV);

  // One double-dabble iteration: correct each BCD nibble, then shift.
  always_comb begin
    logic [19:0] dab;
    dab = shift;
    for (int unsigned i = 0; i < 3; i++) begin
      if (dab[8 + 4*i +: 4] >= 4'd5)
        dab[8 + 4*i +: 4] = dab[8 + 4*i +: 4] + 4'd3;
    end
    shift_nxt = {dab[18:0], 1'b0};
  end

  assign conv_done = !load && (state == S_CONV) && (iter == 3'd7);
  assign bcd_nxt   = conv_done ? shift_nxt[19:8] : bcd;
  assign neg_nxt   = conv_done ? neg_pend : neg_disp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      out      <= '0;
      shift    <= '0;
      iter     <= '0;
      neg_pend <= 1'b0;
    end else if (load) begin
      state    <= S_CONV;
      out      <= bus;
      shift    <= {12'd0, conv_in};
      iter     <= '0;
      neg_pend <= load_neg;
    end else if (state == S_CONV) begin
      shift <= shift_nxt;
      iter  <= iter + 3'd1;
      if (iter == 3'd7)
        state <= S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd      <= '0;
      neg_disp <= 1'b0;
    end else begin
      bcd      <= bcd_nxt;
      neg_disp <= neg_nxt;
    end
  end

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    idx_nxt = (div_cnt == DIV_LAST) ? scan_idx + 2'd1 : scan_idx;
  end

  // seg/an are built from next-state values so fresh digits show the same edge they land.
  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = ~(4'b0001 << idx_nxt);
    case (idx_nxt)
      2'd0: seg_nxt = seg_code(bcd_nxt[3:0]);
      2'd1: if (bcd_nxt[11:4] != 8'd0) seg_nxt = seg_code(bcd_nxt[7:4]);
      2'd2: if (bcd_nxt[11:8] != 4'd0) seg_nxt = seg_code(bcd_nxt[11:8]);
      2'd3: if (neg_nxt) seg_nxt = SEG_DASH;
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      scan_idx <= '0;
      seg      <= 7'b1000000;
      an       <= 4'b1110;
    end else begin
      div_cnt  <= div_nxt;
      scan_idx <= idx_nxt;
      seg      <= seg_nxt;
      an       <= an_nxt;
    end
  end

endmodule

// File: tb/tb_out_display.sv
// Self-checking bench for out_display: directed cases plus random loads,
// compared against a decimal-arithmetic model of the display.
module tb_out_display;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] bus;
  logic [7:0] out;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  out_display #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .bus  (bus),
    .out  (out),
    .busy (busy),
    .seg  (seg),
    .an   (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int         ecnt;
  logic [7:0] out_m;
  logic [7:0] pend_val;
  int         pend;
  logic [7:0] shown;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input logic [7:0] v);
    int  m;
    bit  neg;
    m   = int'(v);
    neg = 1'b0;
`ifdef SIGNED_DISPLAY_EN
    if (v >= 8'd128) begin
      m   = 256 - int'(v);
      neg = 1'b1;
    end
`endif
    case (idx)
      0: return digit_seg(m % 10);
      1: return (m >= 10) ? digit_seg((m / 10) % 10) : 7'b1111111;
      2: return (m >= 100) ? digit_seg(m / 100) : 7'b1111111;
      default: return neg ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    ecnt  = 0;
    out_m = 8'd0;
    pend  = 0;
    shown = 8'd0;
  endtask

  task automatic tick();
    int idx;
    @(posedge clk);
    ecnt++;
    if (load) begin
      out_m    = bus;
      pend_val = bus;
      pend     = 8;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) shown = pend_val;
    end
    @(negedge clk);
    idx = (ecnt / DIV) % 4;
    chk("out", out, out_m);
    chk("busy", {7'd0, busy}, {7'd0, pend > 0});
    chk("an", {4'd0, an}, {4'd0, ~(4'b0001 << idx)});
    chk("seg", {1'b0, seg}, {1'b0, exp_seg(idx, shown)});
  endtask

  task automatic do_load(input logic [7:0] v, input int wait_cycles);
    load = 1'b1;
    bus  = v;
    tick();
    load = 1'b0;
    for (int i = 0; i < wait_cycles; i++) tick();
  endtask

  task automatic check_reset_vals();
    chk("rst_out", out, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_an", {4'd0, an}, 8'h0E);
    chk("rst_seg", {1'b0, seg}, 8'h40);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    bus  = 8'd0;
    #1 rst = 1'b0;
    #2 check_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Full-scale value, then watch two full scan periods.
    do_load(8'd255, 40);
    do_load(8'd7, 20);

    // Restart mid-conversion: 200 must never reach the display.
    do_load(8'd200, 2);
    do_load(8'd13, 24);

    do_load(8'd100, 10);
    do_load(8'd0, 20);

    do_load(8'hF6, 20);
    do_load(8'h80, 20);

    // Asynchronous reset in the middle of a conversion.
    do_load(8'd99, 3);
    rst = 1'b0;
    #1 check_reset_vals();
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) tick();

    // load held high: recapture every edge, digits stay put.
    do_load(8'd42, 12);
    load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus = 8'(i * 37 + 5);
      tick();
    end
    load = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    for (int i = 0; i < 40; i++)
      do_load(8'($urandom_range(0, 255)), $urandom_range(0, 18));
    for (int i = 0; i < 24; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
